// File: rtl/int_arbiter.sv
// Interrupt arbiter: synchronizes raw sources, latches edge/level pending bits,
// and presents the lowest enabled pending source to the CPU as a one-hot request.
module int_arbiter #(
  parameter int unsigned CH    = 8,
  parameter int unsigned VEC_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    src,
  input  logic             cfg_cs,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wr_data,
  output logic [31:0]      cfg_rd_data,
  input  logic             int_ack,
  output logic [CH-1:0]    irq
);

  typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

  state_e             state_q, state_d;
  logic [CH-1:0]      sync1_q, sync2_q, hist_q;
  logic [CH-1:0]      mode_q, mode_d;
  logic [CH-1:0]      pend_q, pend_d;
  logic [CH-1:0]      enable_q, enable_d;
  logic [CH-1:0]      irq_q, irq_d;
  logic [VEC_W-1:0]   cur_vec_q, cur_vec_d;

  logic               wr_en;
  logic [CH-1:0]      wdata;
  logic [CH-1:0]      edge_set;
  logic [CH-1:0]      qual;
  logic [CH-1:0]      win_oh;
  logic [CH-1:0]      ack_clr;
  logic [CH-1:0]      pend_edge;
  logic [VEC_W-1:0]   win;
  logic               any_q;
  logic               busy;
  logic               unused_wr;

  assign unused_wr = ^cfg_wr_data[31:CH];

  assign wr_en    = cfg_cs & cfg_we;
  assign wdata    = cfg_wr_data[CH-1:0];
  assign edge_set = sync2_q & ~hist_q & mode_q;
  assign qual     = pend_q & enable_q;
  assign any_q    = |qual;
  assign win_oh   = CH'(1) << win;
  assign busy     = (state_q == StServ);
  assign irq      = irq_q;

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (qual[i]) win = VEC_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_d     = '0;
    cur_vec_d = cur_vec_q;
    ack_clr   = '0;
    unique case (state_q)
      StIdle: begin
        if (any_q) begin
          state_d = StReq;
          irq_d   = win_oh;
        end
      end
      StReq: begin
        if (!any_q) begin
          state_d = StIdle;
        end else if (int_ack) begin
          state_d   = StServ;
          cur_vec_d = win;
          ack_clr   = win_oh & mode_q;
        end else begin
          irq_d = win_oh;
        end
      end
      StServ: begin
        if (wr_en && cfg_addr == 2'd3) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clears are applied before the edge set so a coincident new edge survives.
  always_comb begin
    mode_d    = mode_q;
    enable_d  = enable_q;
    pend_edge = pend_q & ~ack_clr;
    if (wr_en && cfg_addr == 2'd0) mode_d = wdata;
    if (wr_en && cfg_addr == 2'd2) enable_d = wdata;
    if (wr_en && cfg_addr == 2'd1) pend_edge = pend_edge & ~(wdata & mode_q);
    pend_edge = pend_edge | edge_set;
    pend_d    = (pend_edge & mode_q) | (sync2_q & ~mode_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      cur_vec_q <= '0;
      irq_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= src;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      cur_vec_q <= cur_vec_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    cfg_rd_data = '0;
    if (cfg_cs) begin
      case (cfg_addr)
        2'd0: cfg_rd_data[CH-1:0] = mode_q;
        2'd1: cfg_rd_data[CH-1:0] = pend_q;
        2'd2: cfg_rd_data[CH-1:0] = enable_q;
        default: begin
          cfg_rd_data[VEC_W-1:0] = cur_vec_q;
          cfg_rd_data[VEC_W]     = busy;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: register vector table plus directed
// sequences for edge/level pending, acknowledge, EOI and reset abort.
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        cfg_cs, cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wr_data;
  logic [31:0] cfg_rd_data;
  logic        int_ack;
  logic [7:0]  irq;

  int tests = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  int_arbiter #(.CH(8), .VEC_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .src         (src),
    .cfg_cs      (cfg_cs),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_rd_data (cfg_rd_data),
    .int_ack     (int_ack),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rd(input string name, input logic [1:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    cfg_cs   = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = addr;
    #1;
    check(name, cfg_rd_data, exp_q.pop_front());
    cfg_cs = 1'b0;
  endtask

  task automatic expect_irq(input string name, input logic [7:0] exp);
    exp_q.push_back({24'h0, exp});
    check(name, {24'h0, irq}, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_cs      = 1'b1;
    cfg_we      = 1'b1;
    cfg_addr    = addr;
    cfg_wr_data = data;
    tick();
    cfg_cs = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src   = '0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0,  "rst_mode"};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0,  "rst_pend"};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h0,  "rst_enable"};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,        32'h0,  "rst_cur"};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 32'hFFFFFFA5, 32'h0,  "wr_mode"};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'hA5, "mode_rd"};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h0000FF3C, 32'h0,  "wr_enable"};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,        32'h3C, "enable_rd"};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0,        32'h0,  "cs_low_rd"};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'h0,  "wr_mode0"};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0,  "wr_enable0"};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0,  "mode_rd0"};

    reset = 1'b1; src = '0; cfg_cs = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wr_data = '0; int_ack = 1'b0;
    do_reset();
    expect_irq("rst_irq", 8'h00);

    for (int i = 0; i < 12; i++) begin
      cfg_cs      = vecs[i].cs;
      cfg_we      = vecs[i].we;
      cfg_addr    = vecs[i].addr;
      cfg_wr_data = vecs[i].wdata;
      if (vecs[i].we) begin
        tick();
      end else begin
        exp_q.push_back(vecs[i].exp);
        #1;
        check(vecs[i].name, cfg_rd_data, exp_q.pop_front());
      end
      cfg_cs = 1'b0;
      cfg_we = 1'b0;
    end

    // Edge pulse on bit 5, latency to irq, and EOI ignored while requesting.
    do_reset();
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'hFF);
    src[5] = 1'b1;
    tick(2);
    expect_rd("pend_before_set", 2'd1, 32'h00);
    tick();
    expect_rd("pend_edge5", 2'd1, 32'h20);
    expect_irq("irq_not_yet", 8'h00);
    tick();
    expect_irq("irq_edge5", 8'h20);
    src[5] = 1'b0;
    tick(3);
    expect_irq("irq_holds", 8'h20);
    wr(2'd3, 32'h0);
    expect_irq("eoi_ignored_req", 8'h20);
    expect_rd("not_busy_req", 2'd3, 32'h00);

    // Add bit 2, acknowledge it, EOI, then bit 5 re-requests.
    src[2] = 1'b1;
    tick(4);
    src[2] = 1'b0;
    expect_rd("pend_24", 2'd1, 32'h24);
    expect_irq("irq_lowest", 8'h04);
    ack();
    expect_irq("irq_serv", 8'h00);
    expect_rd("pend_after_ack", 2'd1, 32'h20);
    expect_rd("cur_serv", 2'd3, 32'h0A);
    ack();
    expect_rd("ack_ignored_serv", 2'd3, 32'h0A);
    wr(2'd3, 32'h0);
    expect_irq("irq_after_eoi", 8'h00);
    expect_rd("cur_after_eoi", 2'd3, 32'h02);
    tick();
    expect_irq("irq_rerequest", 8'h20);

    // Write-1-to-clear coinciding with a new edge: the set wins.
    do_reset();
    wr(2'd0, 32'h08);
    src[3] = 1'b1;
    tick(2);
    cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wr_data = 32'h08;
    tick();
    cfg_cs = 1'b0; cfg_we = 1'b0;
    expect_rd("set_wins", 2'd1, 32'h08);
    wr(2'd1, 32'h08);
    expect_rd("w1c_clears", 2'd1, 32'h00);
    src[3] = 1'b0;

    // Level mode on bit 0.
    do_reset();
    wr(2'd2, 32'h01);
    src[0] = 1'b1;
    tick(4);
    expect_irq("irq_level", 8'h01);
    ack();
    expect_rd("level_pend_stays", 2'd1, 32'h01);
    expect_rd("cur_level", 2'd3, 32'h08);
    expect_irq("irq_level_serv", 8'h00);
    wr(2'd3, 32'h0);
    tick();
    expect_irq("irq_level_again", 8'h01);
    src[0] = 1'b0;
    tick(2);
    expect_rd("level_pend_lag", 2'd1, 32'h01);
    tick();
    expect_rd("level_pend_drop", 2'd1, 32'h00);
    tick();
    expect_irq("irq_level_drop", 8'h00);

    // Disable while requesting: back to idle, later ack ignored.
    do_reset();
    wr(2'd0, 32'h10);
    wr(2'd2, 32'h10);
    src[4] = 1'b1;
    tick(4);
    src[4] = 1'b0;
    expect_irq("irq_bit4", 8'h10);
    wr(2'd2, 32'h00);
    tick();
    expect_irq("irq_disabled", 8'h00);
    ack();
    expect_rd("ack_ignored_idle", 2'd3, 32'h00);
    tick();
    expect_irq("irq_stays_idle", 8'h00);
    expect_rd("pend_kept", 2'd1, 32'h10);

    // Reset during service aborts it.
    do_reset();
    wr(2'd0, 32'h02);
    wr(2'd2, 32'h02);
    src[1] = 1'b1;
    tick(4);
    src[1] = 1'b0;
    ack();
    expect_rd("cur_before_abort", 2'd3, 32'h09);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_rd("abort_cur", 2'd3, 32'h00);
    expect_rd("abort_mode", 2'd0, 32'h00);
    expect_rd("abort_pend", 2'd1, 32'h00);
    expect_rd("abort_enable", 2'd2, 32'h00);
    expect_irq("abort_irq", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 The block SHALL have parameter CH, default 8, meaning number of interrupt sources; it equals the CPU IRQ channel count.
REQ-002 The block SHALL have parameter VEC_W, default 3, meaning the width of a source index, ceil(log2(CH)).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port src  input  CH  raw peripheral interrupt lines, asynchronous to clk.
REQ-006 The block SHALL have port cfg_cs  input  1  register access select.
REQ-007 The block SHALL have port cfg_we  input  1  write strobe, qualified by cfg_cs.
REQ-008 The block SHALL have port cfg_addr  input  2  register select: 0 MODE, 1 PEND, 2 ENABLE, 3 CUR/EOI.
REQ-009 The block SHALL have port cfg_wr_data  input  32  write data.
REQ-010 The block SHALL have port cfg_rd_data  output  32  combinational read data.
REQ-011 The block SHALL have port int_ack  input  1  one-cycle pulse from the CPU when it accepts the interrupt.
REQ-012 The block SHALL have port irq  output  CH  registered one-hot request to the CPU control unit.

Function
REQ-013 Each src bit SHALL pass through a 2-flop synchronizer; the second stage is the sampled level s.
REQ-014 Edge mode (MODE bit = 1): a 0->1 change of s between consecutive cycles SHALL set the PEND bit on the next edge.
REQ-015 Level mode (MODE bit = 0): the PEND bit SHALL equal s, registered.
REQ-016 A PEND write SHALL clear each edge-mode bit written as 1; ones in level-mode bit positions SHALL be ignored.
REQ-017 When a new edge and a write-1-to-clear hit the same bit in the same cycle, the set SHALL win.
REQ-018 Qualified set q SHALL be PEND & ENABLE; the winner SHALL be the lowest set index of q.
REQ-019 The FSM SHALL have three states: IDLE, REQ and SERV.
REQ-020 IDLE: irq = 0; when q != 0, go to REQ on the next edge.
REQ-021 REQ: irq SHALL be registered one-hot of the current winner, re-evaluated every cycle.
REQ-022 REQ with q = 0 (bits cleared or disabled before acknowledge): return to IDLE; irq falls at that transition.
REQ-023 REQ with int_ack: capture the winner into cur_vec; clear its PEND bit if edge mode; go to SERV; irq = 0 from the next cycle.
REQ-024 SERV: irq = 0 and new edges still latch into PEND; there is no nesting and no preemption.
REQ-025 SERV: a write to address 3 (EOI, data ignored) SHALL go to IDLE on the next edge.
REQ-026 int_ack SHALL be ignored in IDLE and SERV.
REQ-027 An EOI write SHALL be ignored outside SERV.
REQ-028 Reads at address 0, 1 and 2 SHALL return {zeros, MODE}, {zeros, PEND} and {zeros, ENABLE}.
REQ-029 A read at address 3 SHALL return {zeros, busy, cur_vec}, busy at bit VEC_W, busy = (state == SERV).
REQ-030 Reads SHALL be zero-extended to 32 bits; only cfg_wr_data[CH-1:0] SHALL be used for writes.
REQ-031 With cfg_cs = 0, cfg_rd_data SHALL be 0.
REQ-032 An edge on src visible in s at cycle n SHALL set PEND at n+1, giving irq at n+2 when enabled and IDLE.

Reset
REQ-033 On reset the following SHALL clear to 0: state to IDLE, synchronizers, edge history, MODE, PEND, ENABLE, cur_vec and irq.
REQ-034 Reset asserted in any state, including SERV, SHALL abort service with no EOI required.
REQ-035 For the whole first cycle after reset deasserts, src SHALL NOT produce a spurious edge, because edge history is reset to 0 alongside s.

Verification
REQ-036 Setup MODE = 0xFF, ENABLE = 0xFF; pulse src[5] high for 4 cycles -> PEND = 0x20, irq = 0x20 two cycles after s rises, and stays.
REQ-037 PEND = 0x24, then int_ack -> cur_vec = 2, busy = 1, irq = 0, PEND = 0x20; EOI write -> IDLE, then irq = 0x20.
REQ-038 Level mode on bit 0, src[0] held high, int_ack -> PEND[0] stays 1; after EOI irq = 0x01 again; src[0] low -> PEND[0] = 0 after synchronizer delay.
REQ-039 Write PEND = 0x08 in the same cycle as a new edge on bit 3 -> PEND[3] remains 1.
REQ-040 In REQ with irq = 0x10, write ENABLE = 0x00 -> q = 0, irq = 0 and IDLE the next cycle; int_ack pulse afterwards -> no state change.
REQ-041 In SERV, assert reset for 1 cycle -> state IDLE, CUR read = 0, all registers 0, irq = 0.
